// File: rtl/hazard_pkg.sv
// Shared types for the hazard/sequencing controller: FSM state encoding,
// register-number width and the pipeline control bundle.
package hazard_pkg;

   localparam int REG_W   = 5;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN     = 2'd0,
      ST_MISS    = 2'd1,
      ST_RECOVER = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_flush;
      logic stall;
      logic id_ex_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_HOLD = '{pc_write: 1'b0, if_id_write: 1'b0, if_flush: 1'b0,
                                   stall: 1'b1, id_ex_bubble: 1'b0};

   // Flow control when no cache miss is being honoured: a taken branch
   // wins over a load-use bubble, which is dropped rather than deferred.
   function automatic ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
      ctrl_t c;
      c = '0;
      if (branch_taken) begin
         c.pc_write    = 1'b1;
         c.if_id_write = 1'b1;
         c.if_flush    = 1'b1;
      end else if (load_use) begin
         c.id_ex_bubble = 1'b1;
      end else begin
         c.pc_write    = 1'b1;
         c.if_id_write = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the EX-stage load writes a non-zero register
// that the instruction in ID reads.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   output logic             load_use_o
);

   assign load_use_o = ex_memread_i && (ex_rt_i != '0) &&
                       ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard and cache-miss sequencing FSM with sticky miss timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_seq_ctrl
   import hazard_pkg::*;
#(
   parameter int MISS_TIMEOUT = 1023,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_W-1:0]    id_rs,
   input  logic [REG_W-1:0]    id_rt,
   input  logic                ex_memread,
   input  logic [REG_W-1:0]    ex_rt,
   input  logic                branch_taken,
   input  logic                icache_busy,
   input  logic                dcache_busy,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                if_flush,
   output logic                stall,
   output logic                id_ex_bubble,
   output logic [STATE_W-1:0]  state,
   output logic                timeout_err,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt
);

   localparam int TMO_W = ($clog2(MISS_TIMEOUT + 1) < 1) ? 1 : $clog2(MISS_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MISS_TIMEOUT);

   state_e           state_q, state_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             cache_busy;
   logic             load_use;
   ctrl_t            ctrl;

   assign cache_busy = icache_busy | dcache_busy;

   load_use_detect u_load_use_detect (
      .ex_memread_i (ex_memread),
      .ex_rt_i      (ex_rt),
      .id_rs_i      (id_rs),
      .id_rt_i      (id_rt),
      .load_use_o   (load_use)
   );

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      ctrl    = '0;
      case (state_q)
         ST_RUN: begin
            if (cache_busy) begin
               ctrl    = CTRL_HOLD;
               state_d = ST_MISS;
               tmo_d   = '0;
            end else begin
               ctrl = run_ctrl(branch_taken, load_use);
            end
         end
         ST_MISS: begin
            ctrl = CTRL_HOLD;
            // Count only cycles that stay in MISS so the flag appears in the
            // first MISS cycle beyond MISS_TIMEOUT, then the counter parks.
            if (cache_busy) begin
               if (tmo_q != TMO_MAX) begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
               if (tmo_d == TMO_MAX) begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = ST_RECOVER;
            end
         end
         ST_RECOVER: begin
            ctrl = run_ctrl(branch_taken, load_use);
            if (cache_busy) begin
               state_d = ST_MISS;
               tmo_d   = '0;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            ctrl    = cache_busy ? CTRL_HOLD : run_ctrl(branch_taken, load_use);
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign pc_write     = ctrl.pc_write;
   assign if_id_write  = ctrl.if_id_write;
   assign if_flush     = ctrl.if_flush;
   assign stall        = ctrl.stall;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign state        = state_q;
   assign timeout_err  = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (ctrl.stall || ctrl.id_ex_bubble) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (ctrl.if_flush) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Self-checking bench for hazard_seq_ctrl: directed hazard scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_hazard_seq_ctrl;

   localparam int TMO = 8;
   localparam int CW  = 8;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs, id_rt, ex_rt;
   logic          ex_memread, branch_taken, icache_busy, dcache_busy;
   logic          pc_write, if_id_write, if_flush, stall, id_ex_bubble;
   logic [1:0]    state;
   logic          timeout_err;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: phase 0 = running, 1 = waiting on a miss,
   // 2 = the single recovery cycle after a miss.
   int   m_phase;
   int   m_miss_len;
   logic m_err;
   int   m_stalls;
   int   m_flushes;

   hazard_seq_ctrl #(
      .MISS_TIMEOUT (TMO),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .ex_memread   (ex_memread),
      .ex_rt        (ex_rt),
      .branch_taken (branch_taken),
      .icache_busy  (icache_busy),
      .dcache_busy  (dcache_busy),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_flush     (if_flush),
      .stall        (stall),
      .id_ex_bubble (id_ex_bubble),
      .state        (state),
      .timeout_err  (timeout_err),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase    = 0;
      m_miss_len = 0;
      m_err      = 1'b0;
      m_stalls   = 0;
      m_flushes  = 0;
   endtask

   task automatic drive(input logic ic, input logic dc, input logic br, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
      icache_busy  = ic;
      dcache_busy  = dc;
      branch_taken = br;
      ex_memread   = mr;
      ex_rt        = ert;
      id_rs        = rs;
      id_rt        = rt;
   endtask

   // One clock cycle: apply inputs, check every output against the model,
   // then advance the model to what the next cycle should look like.
   task automatic cyc(input logic ic, input logic dc, input logic br, input logic mr,
                      input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt);
      logic busy, hazard;
      logic [4:0] exp_ctrl;
      int next_phase;
      @(negedge clk);
      drive(ic, dc, br, mr, ert, rs, rt);
      #1;
      busy   = ic | dc;
      hazard = mr && (ert != 0) && (ert == rs || ert == rt);
      // {pc_write, if_id_write, if_flush, stall, id_ex_bubble}
      if (m_phase == 1 || (m_phase == 0 && busy)) exp_ctrl = 5'b00010;
      else if (br)                                  exp_ctrl = 5'b11100;
      else if (hazard)                              exp_ctrl = 5'b00001;
      else                                          exp_ctrl = 5'b11000;
      check_eq("ctrl", {27'd0, pc_write, if_id_write, if_flush, stall, id_ex_bubble}, {27'd0, exp_ctrl});
      check_eq("state", {30'd0, state}, m_phase);
      check_eq("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
      check_eq("stall_cnt", {24'd0, stall_cnt}, m_stalls);
      check_eq("flush_cnt", {24'd0, flush_cnt}, m_flushes);

      if (m_phase == 1) next_phase = busy ? 1 : 2;
      else              next_phase = busy ? 1 : 0;
      if (next_phase == 1) begin
         m_miss_len = (m_phase == 1) ? m_miss_len + 1 : 1;
         if (m_miss_len > TMO) m_err = 1'b1;
      end else begin
         m_miss_len = 0;
      end
      m_phase = next_phase;
`ifdef HAZARD_PERF_CNT_EN
      if (exp_ctrl[1] || exp_ctrl[0]) m_stalls = (m_stalls + 1) % (1 << CW);
      if (exp_ctrl[2])                m_flushes = (m_flushes + 1) % (1 << CW);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   // Reset asserted between edges: effects must be visible before any edge.
   task automatic async_reset();
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("rst_state", {30'd0, state}, 0);
      check_eq("rst_err", {31'd0, timeout_err}, 0);
      check_eq("rst_stall_cnt", {24'd0, stall_cnt}, 0);
      check_eq("rst_flush_cnt", {24'd0, flush_cnt}, 0);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      reset = 1'b1;
      #1;
      check_eq("post_rst_pc_write", {31'd0, pc_write}, 1);
      check_eq("post_rst_state", {30'd0, state}, 0);
   endtask

   initial begin
      int burst;
      logic bsel;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      model_reset();
      #1;
      check_eq("init_state", {30'd0, state}, 0);
      check_eq("init_err", {31'd0, timeout_err}, 0);
      check_eq("init_stall_cnt", {24'd0, stall_cnt}, 0);
      check_eq("init_flush_cnt", {24'd0, flush_cnt}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      idle(2);
      // Load-use on rs, then normal flow once the load has moved on.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0);
      // r0 never creates a hazard; rt match does.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7);
      // Instruction-cache miss for four cycles, then drain to RUN.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(3);
      // Priority: branch over load-use, then data miss over branch.
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0);
      idle(3);
      // Branch and load-use in the recovery cycle.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd1, 5'd9);
      idle(2);
      // Long data miss trips the sticky timeout.
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      idle(3);
      check_eq("timeout_sticky", {31'd0, timeout_err}, 1);
      async_reset();
      // Reset in the middle of a miss.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      async_reset();
      idle(1);

      burst = 0;
      for (int i = 0; i < 700; i++) begin
         if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 11);
         bsel = 1'($urandom_range(0, 1));
         cyc((burst > 0) && bsel, (burst > 0) && !bsel,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         if (burst > 0) burst--;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
